// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the MCP3008-style ADC emulator.
// Holds the responder state encoding and the command frame geometry.
package adc_emu_pkg;

    localparam int CMD_BITS = 5;
    localparam int DEF_RES  = 10;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WAIT_START = 4'd1,
        GET_SGL    = 4'd2,
        GET_D2     = 4'd3,
        GET_D1     = 4'd4,
        GET_D0     = 4'd5,
        NULL_BIT   = 4'd6,
        DATA       = 4'd7,
        TAIL       = 4'd8
    } state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// Four-wire ADC serial bus plus the output enable used to tristate DOUT.
// The master drives clock, select and command; the slave drives data back.
interface adc_spi_if;
    logic ad_clk;
    logic cs;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output ad_clk, output cs, output din, input dout, input dout_oe);
    modport slave  (input ad_clk, input cs, input din, output dout, output dout_oe);
endinterface

// File: rtl/adc_spi_responder_sync.sv
// Multi-stage synchronizer for one asynchronous bus pin.
// Also produces single-clk rise/fall pulses on the synchronized level.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Shift the pin through the synchronizer chain and keep the last level for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r[0] <= pin;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;
endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating a 10-bit MCP3008-class ADC, oversampling the bus with clk.
// Captures the start/SGL/D2..D0 command, then shifts a held sample MSB-first.
module adc_spi_responder
    import adc_emu_pkg::*;
#(
    parameter int RES         = DEF_RES,
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    adc_spi_if.slave           spi,
    input  logic [NCH*RES-1:0] ch_data,
    output logic               cmd_valid,
    output logic               cmd_sgl,
    output logic [2:0]         cmd_ch,
    output logic               frame_done,
    output logic               frame_abort
);
    localparam int IDX_W    = (RES > 1) ? $clog2(RES) : 1;
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

    logic sclk_rise_s, sclk_fall_s, sclk_lvl_s;
    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic din_lvl_s, din_rise_s, din_fall_s;
    logic unused_s;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin(spi.ad_clk),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin(spi.cs),
        .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .pin(spi.din),
        .level(din_lvl_s), .rise(din_rise_s), .fall(din_fall_s));

    assign unused_s = ^{sclk_lvl_s, din_rise_s, din_fall_s};

    // Channel fetch; indexes beyond the emulated channel count read as zero
    function automatic logic [RES-1:0] chan_value(input logic [NCH*RES-1:0] data,
                                                  input logic [2:0] idx);
        if (int'(idx) < NCH) begin
            return data[int'(idx)*RES +: RES];
        end else begin
            return '0;
        end
    endfunction

    // Single-ended value, or IN+ minus IN- clamped at zero for pseudo-differential mode
    function automatic logic [RES-1:0] conv_value(input logic [NCH*RES-1:0] data,
                                                  input logic sgl, input logic [2:0] idx);
        logic [RES:0] diff;
        diff = {1'b0, chan_value(data, idx)} - {1'b0, chan_value(data, idx ^ 3'd1)};
        if (sgl) begin
            return chan_value(data, idx);
        end else if (diff[RES]) begin
            return '0;
        end else begin
            return diff[RES-1:0];
        end
    endfunction

    state_t             state_r;
    logic               armed_r;
    logic [SETTLE_W-1:0] settle_r;
    logic               settled_s;
    logic               sgl_r;
    logic [2:1]         d_r;
    logic [RES-1:0]     sample_r;
    logic [IDX_W-1:0]   idx_r;
    logic               last_r;
    logic               dout_r;
    logic               dout_oe_r;

    // armed_r blocks a frame until CS has been seen high after the synchronizers hold real samples
    assign settled_s = (settle_r == SETTLE_W'(SYNC_STAGES + 1));

    // Frame state machine with all bus and status outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            armed_r       <= 1'b0;
            settle_r      <= '0;
            sgl_r         <= 1'b0;
            d_r           <= 2'b00;
            sample_r      <= '0;
            idx_r         <= '0;
            last_r        <= 1'b0;
            dout_r        <= 1'b0;
            dout_oe_r     <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_sgl       <= 1'b0;
            cmd_ch        <= 3'd0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (!settled_s) begin
                settle_r <= settle_r + SETTLE_W'(1);
            end
            if (cs_rise_s) begin
                state_r   <= IDLE;
                armed_r   <= 1'b1;
                dout_r    <= 1'b0;
                dout_oe_r <= 1'b0;
                case (state_r)
                    TAIL: frame_done <= 1'b1;
                    GET_SGL, GET_D2, GET_D1, GET_D0, NULL_BIT, DATA: frame_abort <= 1'b1;
                    default: ;
                endcase
            end else if (cs_fall_s) begin
                if (state_r == IDLE && armed_r) begin
                    state_r <= WAIT_START;
                    armed_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (settled_s && cs_lvl_s) armed_r <= 1'b1;
                    end
                    WAIT_START: begin
                        if (sclk_rise_s && din_lvl_s) state_r <= GET_SGL;
                    end
                    GET_SGL: begin
                        if (sclk_rise_s) begin
                            sgl_r   <= din_lvl_s;
                            state_r <= GET_D2;
                        end
                    end
                    GET_D2: begin
                        if (sclk_rise_s) begin
                            d_r[2]  <= din_lvl_s;
                            state_r <= GET_D1;
                        end
                    end
                    GET_D1: begin
                        if (sclk_rise_s) begin
                            d_r[1]  <= din_lvl_s;
                            state_r <= GET_D0;
                        end
                    end
                    GET_D0: begin
                        if (sclk_rise_s) begin
                            cmd_sgl   <= sgl_r;
                            cmd_ch    <= {d_r[2], d_r[1], din_lvl_s};
                            cmd_valid <= 1'b1;
                            sample_r  <= conv_value(ch_data, sgl_r, {d_r[2], d_r[1], din_lvl_s});
                            state_r   <= NULL_BIT;
                        end
                    end
                    NULL_BIT: begin
                        if (sclk_fall_s) begin
                            dout_oe_r <= 1'b1;
                            dout_r    <= 1'b0;
                            idx_r     <= IDX_W'(RES - 1);
                            last_r    <= 1'b0;
                            state_r   <= DATA;
                        end
                    end
                    DATA: begin
                        if (sclk_fall_s) begin
                            if (last_r) begin
                                dout_r  <= 1'b0;
                                state_r <= TAIL;
                            end else begin
                                dout_r <= sample_r[idx_r];
                                if (idx_r == '0) last_r <= 1'b1;
                                else             idx_r  <= idx_r - IDX_W'(1);
                            end
                        end
                    end
                    TAIL: begin
                        dout_r    <= 1'b0;
                        dout_oe_r <= 1'b1;
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign spi.dout    = dout_r;
    assign spi.dout_oe = dout_oe_r;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed, table-driven bench for adc_spi_responder acting as an SPI master.
module tb_adc_spi_responder;
    localparam int RES  = 10;
    localparam int NCH  = 8;
    localparam int HALF = 8;

    logic               clk;
    logic               rst_n;
    logic [NCH*RES-1:0] ch_data;
    logic               cmd_valid, cmd_sgl, frame_done, frame_abort;
    logic [2:0]         cmd_ch;
    logic [RES-1:0]     ch [NCH];

    adc_spi_if bus ();

    adc_spi_responder #(.RES(RES), .NCH(NCH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi(bus), .ch_data(ch_data),
        .cmd_valid(cmd_valid), .cmd_sgl(cmd_sgl), .cmd_ch(cmd_ch),
        .frame_done(frame_done), .frame_abort(frame_abort));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NCH; k++) ch_data[k*RES +: RES] = ch[k];
    end

    int n_cmp = 0, n_fail = 0;
    int cv_cnt = 0, fd_cnt = 0, fa_cnt = 0;

    always @(negedge clk) begin
        if (cmd_valid)   cv_cnt++;
        if (frame_done)  fd_cnt++;
        if (frame_abort) fa_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sclk_cycle(input logic d, output logic s);
        @(negedge clk);
        bus.din = d;
        repeat (HALF - 1) @(negedge clk);
        s = bus.dout;
        bus.ad_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ad_clk = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic sgl, input logic [2:0] chn,
                             input int zeros, input int ndata, input bit hold_change,
                             output logic [RES-1:0] word);
        logic s;
        int cv0, fd0, fa0;
        bus.cs = 1'b1;
        repeat (2*HALF) @(negedge clk);
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        cv0 = cv_cnt; fd0 = fd_cnt; fa0 = fa_cnt;
        for (int i = 0; i < zeros; i++) sclk_cycle(1'b0, s);
        sclk_cycle(1'b1, s);
        sclk_cycle(sgl, s);
        sclk_cycle(chn[2], s);
        sclk_cycle(chn[1], s);
        sclk_cycle(chn[0], s);
        chk({name, " cmd_valid"}, cv_cnt - cv0, 1);
        chk({name, " cmd_ch"}, cmd_ch, chn);
        chk({name, " cmd_sgl"}, cmd_sgl, sgl);
        if (hold_change) ch[4] = 10'd5;
        sclk_cycle(1'b0, s);
        chk({name, " null"}, s, 0);
        chk({name, " oe"}, bus.dout_oe, 1);
        word = '0;
        for (int i = 0; i < ndata; i++) begin
            sclk_cycle(1'b0, s);
            word = {word[RES-2:0], s};
        end
        if (ndata == RES) begin
            for (int i = 0; i < 2; i++) begin
                sclk_cycle(1'b0, s);
                chk({name, " tail"}, s, 0);
            end
        end
        repeat (HALF) @(negedge clk);
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, " oe_off"}, bus.dout_oe, 0);
        chk({name, " dout_off"}, bus.dout, 0);
        repeat (4) @(negedge clk);
        chk({name, " done"}, fd_cnt - fd0, (ndata == RES) ? 1 : 0);
        chk({name, " abort"}, fa_cnt - fa0, (ndata == RES) ? 0 : 1);
    endtask

    typedef struct {
        logic           sgl;
        logic [2:0]     chn;
        int             zeros;
        logic [RES-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [RES-1:0] word;
        logic s;
        int cv0, fa0;
        bit seen;

        vecs[0] = '{1'b1, 3'd4, 8, 10'd700};
        vecs[1] = '{1'b0, 3'd3, 2, 10'd0};
        vecs[2] = '{1'b0, 3'd2, 0, 10'd200};
        vecs[3] = '{1'b1, 3'd0, 1, 10'd1023};
        vecs[4] = '{1'b0, 3'd7, 3, 10'd1};
        vecs[5] = '{1'b0, 3'd6, 0, 10'd0};
        vecs[6] = '{1'b0, 3'd0, 1, 10'd1023};
        vecs[7] = '{1'b0, 3'd1, 0, 10'd0};
        vecs[8] = '{1'b1, 3'd5, 0, 10'd37};

        ch[0] = 10'd1023; ch[1] = 10'd0;   ch[2] = 10'd500; ch[3] = 10'd300;
        ch[4] = 10'd700;  ch[5] = 10'd37;  ch[6] = 10'd512; ch[7] = 10'd513;

        rst_n = 1'b0; bus.cs = 1'b1; bus.ad_clk = 1'b0; bus.din = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst dout", bus.dout, 0);
        chk("rst oe", bus.dout_oe, 0);
        chk("rst cmd_ch", cmd_ch, 0);
        chk("rst cmd_sgl", cmd_sgl, 0);
        rst_n = 1'b1;

        // Clock activity with CS high must be ignored
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sclk_cycle(1'b1, s);
            if (bus.dout_oe || bus.dout) seen = 1'b1;
        end
        chk("idle bus quiet", seen, 0);
        chk("idle pulses", cv_cnt + fd_cnt + fa_cnt, 0);

        for (int v = 0; v < 9; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].sgl, vecs[v].chn, vecs[v].zeros, RES, 1'b0, word);
            chk($sformatf("vec%0d word", v), word, vecs[v].exp);
        end

        run_frame("abort", 1'b1, 3'd4, 0, 4, 1'b0, word);
        chk("abort partial", word, 10'd10);
        run_frame("post_abort", 1'b1, 3'd2, 0, RES, 1'b0, word);
        chk("post_abort word", word, 10'd500);

        run_frame("hold", 1'b1, 3'd4, 0, RES, 1'b1, word);
        chk("hold word", word, 10'd700);
        run_frame("hold_next", 1'b1, 3'd4, 0, RES, 1'b0, word);
        chk("hold_next word", word, 10'd5);
        ch[4] = 10'd700;

        // Reset in the middle of a data phase with CS held low
        bus.cs = 1'b1;
        repeat (2*HALF) @(negedge clk);
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk_cycle(1'b1, s); sclk_cycle(1'b1, s); sclk_cycle(1'b1, s);
        sclk_cycle(1'b0, s); sclk_cycle(1'b0, s);
        for (int i = 0; i < 4; i++) sclk_cycle(1'b0, s);
        chk("pre_rst oe", bus.dout_oe, 1);
        fa0 = fa_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst oe", bus.dout_oe, 0);
        chk("mid_rst cmd_ch", cmd_ch, 0);
        chk("mid_rst cmd_sgl", cmd_sgl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cv0 = cv_cnt;
        seen = 1'b0;
        sclk_cycle(1'b1, s); sclk_cycle(1'b1, s); sclk_cycle(1'b1, s);
        sclk_cycle(1'b0, s); sclk_cycle(1'b0, s);
        for (int i = 0; i < 11; i++) begin
            sclk_cycle(1'b0, s);
            if (bus.dout_oe) seen = 1'b1;
        end
        chk("rst_low_cs oe", seen, 0);
        chk("rst_low_cs cmd", cv_cnt - cv0, 0);
        chk("rst no abort", fa_cnt - fa0, 0);
        run_frame("post_rst", 1'b1, 3'd4, 0, RES, 1'b0, word);
        chk("post_rst word", word, 10'd700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI slave that emulates an MCP3008-class 10-bit ADC on the AD_CLK/CS/DIN/DOUT bus.
- Responds to the same start/SGL/D2..D0 command frame the motor-control top issues for the accelerator input.
- Used for hardware-in-loop runs without the physical ADC, and as a self-checking bench partner for the ADC polling logic.
- Samples the bus with the system clock; the bus is never used as a clock.

Parameters:
- RES, 10, conversion width in bits (MSB-first output).
- NCH, 8, number of emulated input channels (power of 2, max 8).
- SYNC_STAGES, 2, synchronizer depth on ad_clk, cs and din.

Ports:
- clk  in  1  system clock (27 MHz); must be at least 8x the ad_clk rate.
- rst_n  in  1  synchronous active-low reset.
- ad_clk  in  1  SPI serial clock from the master, idle low.
- cs  in  1  chip select, active low.
- din  in  1  command bits from the master, sampled on ad_clk rising edge.
- ch_data  in  NCH*RES  packed channel values; channel k is at [k*RES +: RES].
- dout  out  1  serial conversion data.
- dout_oe  out  1  output enable; the top level tristates DOUT when 0.
- cmd_valid  out  1  one-clk pulse when the D0 bit is captured.
- cmd_sgl  out  1  captured SGL bit; held until the next cmd_valid.
- cmd_ch  out  3  captured {D2,D1,D0}; held until the next cmd_valid.
- frame_done  out  1  one-clk pulse on CS rise after all RES bits were shifted.
- frame_abort  out  1  one-clk pulse on CS rise after the start bit but before the last data bit.

Behaviour:
- Reset values:
  - Outputs dout, dout_oe, cmd_valid, cmd_sgl, cmd_ch, frame_done, frame_abort all reset to 0.
  - State resets to IDLE.
  - Synchronizer flops reset to ad_clk=0, cs=1, din=0.
- Edge detection: edges are detected on the synchronized signals. Response latency from a pin edge is SYNC_STAGES+1 clk.
- Priority: a CS edge wins over an ad_clk edge detected in the same clk, and that ad_clk edge is discarded.
- States:
  - IDLE: on cs fall -> WAIT_START. After reset, a frame starts only on a cs fall; if CS is already low at reset release, the block waits for CS to rise and fall.
  - WAIT_START: each sclk rise with din=0 stays here (leading zeros allowed, any count). A sclk rise with din=1 -> GET_SGL.
  - GET_SGL, GET_D2, GET_D1, GET_D0: capture one bit per sclk rise. On the D0 capture:
    - update cmd_sgl and cmd_ch;
    - pulse cmd_valid;
    - latch the sample register (sample/hold);
    - go to NULL_BIT.
  - NULL_BIT: on the next sclk fall, set dout_oe=1 and dout=0, then go to DATA with bit index = RES-1.
  - DATA: on each sclk fall, dout = sample[idx]. When idx reaches 0 (bit already driven), go to TAIL on the next sclk fall.
  - TAIL: dout=0 and dout_oe=1 until CS rises.
- Sample value:
  - SGL=1: ch_data[cmd_ch].
  - SGL=0: pseudo-differential, IN+ = ch[cmd_ch] and IN- = ch[cmd_ch ^ 1]. Result is IN+ minus IN-, saturated at 0, computed RES+1 bits wide.
  - Channel indexes >= NCH read as 0.
  - ch_data changes after the latch do not affect the frame in progress.
- CS rise in any state:
  - dout_oe=0 and dout=0 within SYNC_STAGES+1 clk; go to IDLE.
  - From TAIL: pulse frame_done.
  - From GET_* / NULL_BIT / DATA: pulse frame_abort.
  - From IDLE / WAIT_START: no pulse.
- Extra sclk edges in TAIL are ignored. SCLK edges while CS is high are ignored.
- rst_n low mid-frame: state returns to IDLE next clk; all outputs go to reset values; no abort pulse.

Decomposition:
- Package adc_emu_pkg holds:
  - state enum (IDLE, WAIT_START, GET_SGL, GET_D2, GET_D1, GET_D0, NULL_BIT, DATA, TAIL);
  - constants CMD_BITS=5 and the default RES.
- Sub-module spi_in_sync: SYNC_STAGES-deep synchronizer plus rise/fall pulse generator, instantiated once per bus input (ad_clk, cs, din).

Test Plan:
- Reset with CS high, then toggle ad_clk 20 times -> dout_oe=0, dout=0, no pulses.
- Master-style frame: 8 zeros, start, SGL=1, D=1,0,0, two idle clocks, ch_data[4]=700 -> cmd_valid with cmd_ch=4, cmd_sgl=1. DOUT sampled on rises reads null 0, then 1010111100. CS rise -> frame_done for exactly 1 clk.
- Differential with ch2=500, ch3=300:
  - D=0,1,1 -> output 0 (saturated);
  - D=0,1,0 -> output 200 (0011001000).
- Abort: CS rise after 4 data bits -> frame_abort pulse, dout_oe=0 within 3 clk. The next frame returns the correct value.
- Sample/hold: change ch_data[4] from 700 to 5 right after cmd_valid -> the frame still shifts 700; the next frame shifts 5.
- rst_n low for 2 clk in DATA with CS held low -> outputs 0. Release with CS low and clock 16 bits -> no response until a CS high-low toggle, after which the frame is normal.
